pe_mac_seq: RTL and testbench

- Job sequencer for one PE MAC core: accepts a dot-product job (length, accumulate mode) on a config port, streams operand pairs into the PE, and returns the final 24-bit sum on a valid/ready result port.
- Owns generation of the PE's read_in, mode_sel and clr_acc pulses, so upstream logic never drives the PE directly.
- Sits between the operand buffer/stream and the PE core; one instance per PE.

---
 rtl/pe_pkg.sv | 19 +
 rtl/pe_mac_seq.sv | 129 ++++++++++++
 tb/tb_pe_mac_seq.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared types and widths for the PE MAC job sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pe_pkg;

  // Operand width on the PE multiplier inputs.
  localparam int PE_OP_W  = 8;
  // Accumulator / result width of the PE.
  localparam int PE_ACC_W = 24;

  // Job sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } pe_state_e;

endpackage

// File: rtl/pe_mac_seq.sv
// Job sequencer for one PE MAC core: streams a dot-product job into the PE and returns its sum.
// Latency: N back-to-back beats starting at T give pe_out_vld at T+N and res_valid at T+N+1.
// Backpressure: op_ready only in RUN; the result is held until res_ready; cfg_abort overrides all.
module pe_mac_seq
  import pe_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  // job configuration
  input  logic                       cfg_start,
  input  logic [LEN_W-1:0]           cfg_len,
  input  logic                       cfg_accum,
  input  logic                       cfg_abort,
  output logic                       busy,
  output logic                       err_len,
  // operand stream
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [PE_OP_W-1:0]         op_a,
  input  logic signed [PE_OP_W-1:0]  op_b,
  // PE core interface
  output logic                       pe_read_in,
  output logic                       pe_mode_sel,
  output logic                       pe_clr_acc,
  output logic [PE_OP_W-1:0]         pe_a,
  output logic signed [PE_OP_W-1:0]  pe_b,
  input  logic                       pe_out_vld,
  input  logic signed [PE_ACC_W-1:0] pe_pro_sum,
  // result port
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic signed [PE_ACC_W-1:0] res_data
);

  pe_state_e                  state_q;
  logic [LEN_W-1:0]           cnt_q;
  logic                       first_q;
  logic                       err_len_q;
  logic                       res_valid_q;
  logic signed [PE_ACC_W-1:0] res_data_q;

  logic len_ok;
  logic abort;
  logic beat;

  // A job length is legal only inside 1..MAX_LEN.
  assign len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  // Abort only means something while a job is in flight; in IDLE it is a no-op.
  assign abort = cfg_abort && (state_q != IDLE);

  // Operands flow only in RUN, and an abort in the same cycle blocks the beat.
  assign op_ready = (state_q == RUN) && !cfg_abort;
  assign beat     = op_valid && op_ready;

  // PE drive is combinational with the beat; data lines are zeroed between beats.
  assign pe_read_in  = beat;
  assign pe_mode_sel = beat && !first_q;
  assign pe_a        = beat ? op_a : '0;
  assign pe_b        = beat ? op_b : '0;
  assign pe_clr_acc  = abort;

  assign busy      = (state_q != IDLE);
  assign err_len   = err_len_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

  // Job FSM: length counter, first-beat flag, error pulse and result register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      err_len_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      err_len_q <= 1'b0;
      if (abort) begin
        state_q     <= IDLE;
        res_valid_q <= 1'b0;
        cnt_q       <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cfg_start) begin
              if (len_ok) begin
                cnt_q   <= cfg_len;
                first_q <= !cfg_accum;
                state_q <= RUN;
              end else begin
                err_len_q <= 1'b1;
              end
            end
          end
          RUN: begin
            if (beat) begin
              first_q <= 1'b0;
              cnt_q   <= cnt_q - LEN_W'(1);
              if (cnt_q == LEN_W'(1)) begin
                state_q <= WAIT;
              end
            end
          end
          WAIT: begin
            if (pe_out_vld) begin
              res_data_q  <= pe_pro_sum;
              res_valid_q <= 1'b1;
              state_q     <= RESULT;
            end
          end
          RESULT: begin
            if (res_ready) begin
              res_valid_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_seq.sv
// Self-checking bench for pe_mac_seq with a behavioural PE core attached.
// Latency: n/a (testbench).
// Backpressure: bench drives op_valid gaps and res_ready stalls.
module tb_pe_mac_seq;

  localparam int MAX_LEN = 256;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cfg_start, cfg_accum, cfg_abort;
  logic [LEN_W-1:0] cfg_len;
  logic             busy, err_len;
  logic             op_valid, op_ready;
  logic [7:0]       op_a, op_b;
  logic             pe_read_in, pe_mode_sel, pe_clr_acc;
  logic [7:0]       pe_a, pe_b;
  logic             pe_out_vld;
  logic [23:0]      pe_pro_sum;
  logic             res_valid, res_ready;
  logic [23:0]      res_data;

  always #5 clk = ~clk;

  pe_mac_seq dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_accum(cfg_accum), .cfg_abort(cfg_abort),
    .busy(busy), .err_len(err_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .pe_read_in(pe_read_in), .pe_mode_sel(pe_mode_sel), .pe_clr_acc(pe_clr_acc),
    .pe_a(pe_a), .pe_b(pe_b), .pe_out_vld(pe_out_vld), .pe_pro_sum(pe_pro_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  // Behavioural PE core: unsigned a times signed b, load or accumulate, out_vld one cycle after read_in.
  logic [23:0] pe_prod;
  assign pe_prod = {16'b0, pe_a} * {{16{pe_b[7]}}, pe_b};
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pe_pro_sum <= '0;
      pe_out_vld <= 1'b0;
    end else begin
      pe_out_vld <= pe_read_in;
      if (pe_clr_acc) pe_pro_sum <= '0;
      else if (pe_read_in) pe_pro_sum <= (pe_mode_sel ? pe_pro_sum : 24'd0) + pe_prod;
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Job-level model: beats still owed, waiting for the PE, result pending.
  int          m_left = 0;
  bit          m_wait = 0, m_res = 0, m_first = 0, m_err = 0;
  logic [23:0] m_acc = '0, m_res_val = '0;

  int          rd_cnt = 0, mode_cnt = 0, err_cnt = 0, clr_cnt = 0;
  int          first_rd = -1, rv_cyc = -1;
  bit          prev_rv = 0;
  logic [23:0] got_q[$];

  // Per-cycle comparison of every DUT output against the model, then model advance.
  always @(negedge clk) begin
    bit idle_e, abort_e, rdy_e, beat_e;
    if (!reset_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_err_len", err_len, 0);
      chk("rst_read_in", pe_read_in, 0);
      chk("rst_op_ready", op_ready, 0);
      m_left = 0; m_wait = 0; m_res = 0; m_first = 0; m_err = 0;
      m_acc = '0; m_res_val = '0; prev_rv = 0;
    end else begin
      idle_e  = (m_left == 0) && !m_wait && !m_res;
      abort_e = cfg_abort && !idle_e;
      rdy_e   = (m_left > 0) && !cfg_abort;
      beat_e  = op_valid && rdy_e;
      chk("busy", busy, !idle_e);
      chk("op_ready", op_ready, rdy_e);
      chk("read_in", pe_read_in, beat_e);
      chk("mode_sel", pe_mode_sel, beat_e && !m_first);
      chk("pe_a", pe_a, beat_e ? op_a : 8'd0);
      chk("pe_b", pe_b, beat_e ? op_b : 8'd0);
      chk("clr_acc", pe_clr_acc, abort_e);
      chk("err_len", err_len, m_err);
      chk("res_valid", res_valid, m_res);
      if (m_res) chk("res_data", res_data, m_res_val);

      if (pe_read_in) rd_cnt++;
      if (pe_read_in && pe_mode_sel) mode_cnt++;
      if (err_len) err_cnt++;
      if (pe_clr_acc) clr_cnt++;
      if (pe_read_in && first_rd < 0) first_rd = cyc;
      if (res_valid && !prev_rv) rv_cyc = cyc;
      prev_rv = res_valid;
      if (res_valid && res_ready) got_q.push_back(res_data);

      m_err = 0;
      if (abort_e) begin
        m_left = 0; m_wait = 0; m_res = 0; m_acc = '0;
      end else if (idle_e) begin
        if (cfg_start) begin
          if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
            m_left  = int'(cfg_len);
            m_first = !cfg_accum;
          end else begin
            m_err = 1;
          end
        end
      end else if (m_left > 0) begin
        if (beat_e) begin
          m_acc   = 24'((m_first ? 0 : int'(m_acc)) + int'(op_a) * int'($signed(op_b)));
          m_first = 0;
          m_left--;
          if (m_left == 0) m_wait = 1;
        end
      end else if (m_wait) begin
        if (pe_out_vld) begin
          m_wait = 0; m_res = 1; m_res_val = m_acc;
        end
      end else if (m_res && res_ready) begin
        m_res = 0;
      end
    end
  end

  logic [7:0] ja [0:299];
  logic [7:0] jb [0:299];

  function automatic logic [31:0] last_res();
    if (got_q.size() == 0) return 'x;
    return {8'h0, got_q[got_q.size()-1]};
  endfunction

  // One job: start, stream n operands with a gap pattern, optional abort or reset, collect result.
  task automatic run_job(input int len, input bit accum, input int n, input int gap, input int stall,
                         input bit hs_start, input int abort_after, input bit rst_wait);
    int i, k, guard;
    bit v, r;
    @(posedge clk); #1;
    cfg_start = 1; cfg_len = LEN_W'(len); cfg_accum = accum;
    i = 0; k = 0; guard = 0;
    op_valid = 1; op_a = ja[0]; op_b = jb[0];
    while (i < n && guard < 2000) begin
      @(negedge clk); v = op_valid; r = op_ready;
      @(posedge clk); #1;
      guard++; k++;
      cfg_start = (gap == 2) && ($urandom_range(0, 3) == 0);
      cfg_len   = LEN_W'($urandom_range(0, 511));
      if (v && r) i++;
      if (abort_after >= 0 && i == abort_after) begin
        cfg_abort = 1; op_valid = 1; op_a = 8'($urandom); op_b = 8'($urandom);
        @(posedge clk); #1;
        cfg_abort = 0; op_valid = 0; cfg_start = 0;
        return;
      end
      if (i < n) begin
        if (gap == 0) op_valid = 1;
        else if (gap == 1) op_valid = (k % 2 == 0);
        else op_valid = 1'($urandom_range(0, 1));
        if (op_valid) begin op_a = ja[i]; op_b = jb[i]; end
        else begin op_a = 8'($urandom); op_b = 8'($urandom); end
      end else begin
        op_valid = 0;
      end
    end
    cfg_start = 0; op_valid = 0;
    chk("op_stream_beats", i, n);
    if (rst_wait) begin
      #1;
      chk("wait_busy", busy, 1);
      chk("wait_op_ready", op_ready, 0);
      #1 reset_n = 0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_res_valid", res_valid, 0);
      chk("arst_read_in", pe_read_in, 0);
      @(posedge clk); @(posedge clk); #2;
      reset_n = 1;
      return;
    end
    guard = 0;
    do begin @(negedge clk); guard++; end while (!res_valid && guard < 40);
    chk("res_arrives", res_valid, 1);
    @(posedge clk); #1;
    repeat (stall) begin @(posedge clk); #1; end
    res_ready = 1; cfg_start = hs_start; cfg_len = LEN_W'(1);
    @(posedge clk); #1;
    res_ready = 0; cfg_start = 0;
  endtask

  task automatic illegal(input int len, input bit ab);
    @(posedge clk); #1;
    cfg_start = 1; cfg_len = LEN_W'(len); cfg_abort = ab;
    @(posedge clk); #1;
    cfg_start = 0; cfg_abort = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_rd, b_mode, b_err, b_clr, b_got;
    logic [23:0] sum;
    reset_n = 0; cfg_start = 0; cfg_len = '0; cfg_accum = 0; cfg_abort = 0;
    op_valid = 0; op_a = 0; op_b = 0; res_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_pe_clr", pe_clr_acc, 0);
    @(posedge clk); #2 reset_n = 1;

    // Load job: 10*1 + 20*-2 + 255*-128 = -32670.
    ja[0] = 8'd10;  jb[0] = 8'd1;
    ja[1] = 8'd20;  jb[1] = 8'hFE;
    ja[2] = 8'd255; jb[2] = 8'h80;
    b_rd = rd_cnt; b_mode = mode_cnt; first_rd = -1; rv_cyc = -1;
    run_job(3, 0, 3, 0, 2, 0, -1, 0);
    chk("load_result", last_res(), 32'h00FF8062);
    chk("load_latency", rv_cyc - first_rd, 4);
    chk("load_read_pulses", rd_cnt - b_rd, 3);
    chk("load_mode_pulses", mode_cnt - b_mode, 2);

    // Accumulate job: previous sum + 2*5 = -32660.
    ja[0] = 8'd2; jb[0] = 8'd5;
    b_mode = mode_cnt;
    run_job(1, 1, 1, 0, 0, 0, -1, 0);
    chk("accum_result", last_res(), 32'h00FF806C);
    chk("accum_mode_pulses", mode_cnt - b_mode, 1);

    // Stalled job: gaps every other cycle, result held 5 extra cycles; 1+4+9+16 = 30.
    for (int q = 0; q < 4; q++) begin ja[q] = 8'(q + 1); jb[q] = 8'(q + 1); end
    b_rd = rd_cnt;
    run_job(4, 0, 4, 1, 5, 0, -1, 0);
    chk("stall_read_pulses", rd_cnt - b_rd, 4);
    chk("stall_result", last_res(), 32'd30);

    // Illegal lengths, the second with an abort in IDLE.
    b_err = err_cnt; b_rd = rd_cnt; b_clr = clr_cnt;
    illegal(0, 0);
    illegal(MAX_LEN + 1, 1);
    chk("illegal_err_pulses", err_cnt - b_err, 2);
    chk("illegal_read_pulses", rd_cnt - b_rd, 0);
    chk("idle_abort_clr", clr_cnt - b_clr, 0);
    chk("illegal_busy", busy, 0);

    // Abort after 3 of 8 beats, then a fresh load job 3*-3 = -9.
    for (int q = 0; q < 8; q++) begin ja[q] = 8'(q + 7); jb[q] = 8'(q + 3); end
    b_clr = clr_cnt; b_got = got_q.size();
    run_job(8, 0, 8, 0, 0, 0, 3, 0);
    chk("abort_clr_pulses", clr_cnt - b_clr, 1);
    chk("abort_pe_cleared", pe_pro_sum, 0);
    chk("abort_idle", busy, 0);
    chk("abort_no_result", got_q.size() - b_got, 0);
    ja[0] = 8'd3; jb[0] = 8'hFD;
    run_job(1, 0, 1, 0, 0, 0, -1, 0);
    chk("post_abort_result", last_res(), 32'h00FFFFF7);

    // Reset in WAIT, then 1*1 + 1*1 = 2.
    for (int q = 0; q < 3; q++) begin ja[q] = 8'd9; jb[q] = 8'd9; end
    b_got = got_q.size();
    run_job(3, 0, 3, 0, 0, 0, -1, 1);
    chk("reset_no_result", got_q.size() - b_got, 0);
    ja[0] = 8'd1; jb[0] = 8'd1; ja[1] = 8'd1; jb[1] = 8'd1;
    run_job(2, 0, 2, 0, 0, 0, -1, 0);
    chk("post_reset_result", last_res(), 32'd2);

    // Randomized jobs, gaps, stalls, stray starts and occasional aborts.
    for (int j = 0; j < 25; j++) begin
      int len, ab;
      if ($urandom_range(0, 9) == 0) begin
        illegal(($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(MAX_LEN + 1, 511)),
                1'($urandom_range(0, 1)));
      end else begin
        len = int'($urandom_range(1, 12));
        for (int q = 0; q < len; q++) begin ja[q] = 8'($urandom); jb[q] = 8'($urandom); end
        ab = ($urandom_range(0, 7) == 0 && len > 1) ? int'($urandom_range(1, len - 1)) : -1;
        run_job(len, 1'($urandom_range(0, 1)), len, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ab, 0);
      end
    end

    // Maximum-length job back-to-back, checked against a plain dot product.
    sum = '0;
    for (int q = 0; q < MAX_LEN; q++) begin
      ja[q] = 8'($urandom); jb[q] = 8'($urandom);
      sum = 24'(int'(sum) + int'(ja[q]) * int'($signed(jb[q])));
    end
    b_rd = rd_cnt;
    run_job(MAX_LEN, 0, MAX_LEN, 0, 1, 0, -1, 0);
    chk("maxlen_read_pulses", rd_cnt - b_rd, MAX_LEN);
    chk("maxlen_result", last_res(), {8'h0, sum});

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
